// File: rtl/result_collector_pkg.sv
// Shared defaults and the default-width FIFO entry layout for result_collector.
// The RESULT_PARITY_EN macro adds a stored parity bit to each entry.
package result_collector_pkg;

  localparam int DEF_NUM_CORES = 4;
  localparam int DEF_RES_W     = 8;
  localparam int DEF_DEPTH     = 8;
  localparam int CORE_ID_W     = $clog2(DEF_NUM_CORES);

  typedef struct packed {
    logic [CORE_ID_W-1:0] core_id;
    logic [DEF_RES_W-1:0] data;
`ifdef RESULT_PARITY_EN
    logic                 parity;
`endif
  } entry_t;

endpackage

// File: rtl/result_fifo.sv
// First-word-fall-through synchronous FIFO; head reads as zero while empty.
module result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic                     o_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_count   = r_count;
  assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; r_count qualifies every slot,
  // and the head mux hides stale contents while empty.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/result_collector.sv
// Per-core result hold registers, round-robin arbiter and tagged output FIFO.
// Define RESULT_PARITY_EN to add the out_parity port and stored parity.
module result_collector
  import result_collector_pkg::*;
#(
  parameter int NUM_CORES = DEF_NUM_CORES,
  parameter int RES_W     = DEF_RES_W,
  parameter int DEPTH     = DEF_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CORES-1:0]         core_valid,
  input  logic [NUM_CORES*RES_W-1:0]   core_result,
  output logic [NUM_CORES-1:0]         core_ack,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [RES_W-1:0]             out_data,
  output logic [$clog2(NUM_CORES)-1:0] out_core,
  output logic [$clog2(DEPTH):0]       out_count,
`ifdef RESULT_PARITY_EN
  output logic                         out_parity,
`endif
  output logic [NUM_CORES-1:0]         overflow
);

  localparam int ID_W = $clog2(NUM_CORES);

  typedef struct packed {
    logic [ID_W-1:0]  core_id;
    logic [RES_W-1:0] data;
`ifdef RESULT_PARITY_EN
    logic             parity;
`endif
  } fifo_entry_t;

  logic [NUM_CORES-1:0] r_hold_v;
  logic [RES_W-1:0]     r_hold_data [NUM_CORES];
  logic [ID_W-1:0]      r_last_grant;
  logic [NUM_CORES-1:0] r_core_ack;
  logic [NUM_CORES-1:0] r_overflow;

  logic [NUM_CORES-1:0] w_capture;
  logic [NUM_CORES-1:0] w_grant_vec;
  logic                 w_grant_any;
  logic [ID_W-1:0]      w_grant_idx;
  logic [ID_W-1:0]      w_cand;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  fifo_entry_t          w_push_entry;
  fifo_entry_t          w_head;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    w_cand      = '0;
    if (!w_fifo_full) begin
      for (int k = 1; k <= NUM_CORES; k++) begin
        w_cand = ID_W'((int'(r_last_grant) + k) % NUM_CORES);
        if (!w_grant_any && r_hold_v[w_cand]) begin
          w_grant_any = 1'b1;
          w_grant_idx = w_cand;
        end
      end
    end
    w_grant_vec = w_grant_any ? (NUM_CORES'(1) << w_grant_idx) : '0;
  end

  // A granted core frees its slot this edge, so a coincident strobe recaptures.
  assign w_capture = core_valid & (~r_hold_v | w_grant_vec);

  always_comb begin
    w_push_entry         = '0;
    w_push_entry.core_id = w_grant_idx;
    w_push_entry.data    = r_hold_data[w_grant_idx];
`ifdef RESULT_PARITY_EN
    w_push_entry.parity  = ^{w_grant_idx, r_hold_data[w_grant_idx]};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_v     <= '0;
      r_last_grant <= ID_W'(NUM_CORES - 1);
      r_core_ack   <= '0;
      r_overflow   <= '0;
    end else begin
      r_core_ack <= w_grant_vec;
      if (w_grant_any) r_last_grant <= w_grant_idx;
      for (int i = 0; i < NUM_CORES; i++) begin
        if (w_capture[i])        r_hold_v[i]   <= 1'b1;
        else if (w_grant_vec[i]) r_hold_v[i]   <= 1'b0;
        else if (core_valid[i])  r_overflow[i] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CORES; i++) begin
      if (w_capture[i]) r_hold_data[i] <= core_result[i*RES_W +: RES_W];
    end
  end

  result_fifo #(
    .WIDTH ($bits(fifo_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_grant_any),
    .i_push_data (w_push_entry),
    .i_pop       (out_ready),
    .o_head      (w_head),
    .o_count     (out_count),
    .o_empty     (w_fifo_empty),
    .o_full      (w_fifo_full)
  );

  assign out_valid = !w_fifo_empty;
  assign out_data  = w_head.data;
  assign out_core  = w_head.core_id;
`ifdef RESULT_PARITY_EN
  assign out_parity = w_head.parity;
`endif
  assign core_ack  = r_core_ack;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_result_collector.sv
// Directed-vector bench for result_collector with hand-computed expectations.
module tb_result_collector;
  import result_collector_pkg::*;

  localparam int NC = DEF_NUM_CORES;
  localparam int RW = DEF_RES_W;
  localparam int DP = DEF_DEPTH;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NC-1:0]         core_valid;
  logic [NC*RW-1:0]      core_result;
  logic [NC-1:0]         core_ack;
  logic                  out_valid;
  logic                  out_ready;
  logic [RW-1:0]         out_data;
  logic [$clog2(NC)-1:0] out_core;
  logic [$clog2(DP):0]   out_count;
  logic [NC-1:0]         overflow;
`ifdef RESULT_PARITY_EN
  logic                  out_parity;
`endif

  int n_vec = 0;
  int n_err = 0;

  result_collector dut (
    .clk         (clk),
    .rst         (rst),
    .core_valid  (core_valid),
    .core_result (core_result),
    .core_ack    (core_ack),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_core    (out_core),
    .out_count   (out_count),
`ifdef RESULT_PARITY_EN
    .out_parity  (out_parity),
`endif
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_res(input int core, input logic [RW-1:0] v);
    core_result[core*RW +: RW] = v;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    core_valid  = '0;
    core_result = '0;
    out_ready   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_count", 32'(out_count), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data",  32'(out_data), 0);
    check("rst_core",  32'(out_core), 0);
    check("rst_ack",   32'(core_ack), 0);
    check("rst_ovf",   32'(overflow), 0);

    // Single result from core 0.
    core_valid = 4'b0001;
    set_res(0, 8'h2A);
    tick();
    core_valid = '0;
    check("single_ack_early",   32'(core_ack), 0);
    check("single_valid_early", 32'(out_valid), 0);
    tick();
    check("single_ack",   32'(core_ack), 32'h1);
    check("single_valid", 32'(out_valid), 1);
    check("single_data",  32'(out_data), 32'h2A);
    check("single_core",  32'(out_core), 0);
    check("single_count", 32'(out_count), 1);
    out_ready = 1'b1;
    tick();
    check("single_drained", 32'(out_count), 0);
    check("single_valid0",  32'(out_valid), 0);
    check("single_ack_off", 32'(core_ack), 0);
    tick();
    check("empty_pop_noop", 32'(out_count), 0);

    // Simultaneous strobes from all cores.
    do_reset();
    core_valid = 4'b1111;
    for (int i = 0; i < NC; i++) set_res(i, RW'(8'h10 + i));
    tick();
    core_valid = '0;
    out_ready  = 1'b1;
    for (int i = 0; i < NC; i++) begin
      tick();
      check($sformatf("simul_core%0d", i), 32'(out_core), 32'(i));
      check($sformatf("simul_data%0d", i), 32'(out_data), 32'(8'h10 + i));
      check($sformatf("simul_ack%0d", i),  32'(core_ack), 32'(1 << i));
    end
    tick();
    check("simul_empty", 32'(out_count), 0);
    check("simul_ovf",   32'(overflow), 0);

    // Fairness between cores 0 and 2; each recaptures on its own grant.
    do_reset();
    out_ready  = 1'b1;
    core_valid = 4'b0101;
    set_res(0, 8'hA0);
    set_res(2, 8'hC0);
    tick();
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) begin
        core_valid = 4'b0001;
        set_res(0, RW'(8'hA0 + k/2 + 1));
      end else begin
        core_valid = 4'b0100;
        set_res(2, RW'(8'hC0 + k/2 + 1));
      end
      tick();
      check($sformatf("fair_core%0d", k), 32'(out_core), (k % 2 != 0) ? 32'd2 : 32'd0);
      check($sformatf("fair_data%0d", k), 32'(out_data),
            (k % 2 != 0) ? 32'(8'hC0 + k/2) : 32'(8'hA0 + k/2));
      check($sformatf("fair_ack%0d", k), 32'(core_ack), (k % 2 != 0) ? 32'h4 : 32'h1);
    end
    core_valid = '0;
    check("fair_ovf", 32'(overflow), 0);

    // Backpressure: nine results from core 1 into an eight-entry FIFO.
    do_reset();
    for (int j = 0; j < 9; j++) begin
      core_valid = 4'b0010;
      set_res(1, RW'(8'h50 + j));
      tick();
      core_valid = '0;
      tick();
    end
    check("bp_full",   32'(out_count), 8);
    check("bp_noack",  32'(core_ack), 0);
    check("bp_ovf0",   32'(overflow), 0);
    core_valid = 4'b0010;
    set_res(1, 8'h59);
    tick();
    core_valid = '0;
    tick();
    check("bp_ovf1",   32'(overflow), 32'h2);
    check("bp_still8", 32'(out_count), 8);
    out_ready = 1'b1;
    for (int j = 0; j < 9; j++) begin
      check($sformatf("bp_drain%0d", j), 32'(out_data), 32'(8'h50 + j));
      tick();
    end
    check("bp_empty",  32'(out_count), 0);
    check("bp_sticky", 32'(overflow), 32'h2);

    // Mid-operation reset with three queued entries and hold_v=0110.
    out_ready  = 1'b0;
    core_valid = 4'b0111;
    set_res(0, 8'h70);
    set_res(1, 8'h71);
    set_res(2, 8'h72);
    tick();
    core_valid = '0;
    tick();
    tick();
    tick();
    core_valid = 4'b0110;
    set_res(1, 8'h81);
    set_res(2, 8'h82);
    tick();
    core_valid = '0;
    check("mid_queued", 32'(out_count), 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_count", 32'(out_count), 0);
    check("mid_valid", 32'(out_valid), 0);
    check("mid_ovf",   32'(overflow), 0);
    check("mid_ack",   32'(core_ack), 0);
    core_valid = 4'b0101;
    set_res(0, 8'h90);
    set_res(2, 8'h92);
    tick();
    core_valid = '0;
    tick();
    check("mid_first_core", 32'(out_core), 0);
    check("mid_first_data", 32'(out_data), 32'h90);
    check("mid_first_ack",  32'(core_ack), 32'h1);
    tick();
    check("mid_second_ack", 32'(core_ack), 32'h4);
    check("mid_count2",     32'(out_count), 2);

`ifdef RESULT_PARITY_EN
    do_reset();
    core_valid = 4'b1000;
    set_res(3, 8'h01);
    tick();
    core_valid = '0;
    tick();
    check("par_core", 32'(out_core), 3);
    check("par_odd",  32'(out_parity), 1);
    out_ready  = 1'b1;
    core_valid = 4'b1000;
    set_res(3, 8'h03);
    tick();
    core_valid = '0;
    tick();
    check("par_even", 32'(out_parity), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
